data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the processor's data-memory port: accepts load/store requests over a
//  valid/ready handshake and returns one response per request after a programmable wait-state delay.
//  Models a realistic multi-cycle RAM behind the load/store path; one outstanding request at a time.
// PARAMETERS
//  DEPTH_WORDS   256  number of 32-bit words in the array (power of two)
//  WAIT_CYCLES   2    extra cycles between request accept and response (0..15)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   processor presents a request
//  req_ready  out  1   responder can accept a request this cycle
//  req_write  in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  req_be     in   4   byte enables for stores (bit i -> byte lane i)
//  rsp_valid  out  1   response available
//  rsp_ready  in   1   processor consumes response
//  rsp_rdata  out  32  load data (32'h0 for stores)
//  rsp_err    out  1   access error (always 0 unless DMEM_MISALIGN_CHECK_EN)
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-high. Reset: state=IDLE, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, wait counter=0. Array contents NOT reset. req_ready=0 while reset is high.
//  - FSM states IDLE, WAIT, RESP.
//    IDLE: req_ready=1. On req_valid&&req_ready capture write/addr/wdata/be;
//          -> WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else -> RESP.
//    WAIT: req_ready=0; counter decrements each cycle; at counter==0 -> RESP.
//    RESP: req_ready=0; rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready -> IDLE.
//  - Access performed on the edge entering RESP: store writes enabled byte lanes; load registers word.
//  - Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
//  - Throughput: next request accepted no earlier than the cycle after the response handshake.
//  - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
//  - Loads return full word regardless of req_be. Store with req_be=4'b0000: no array change,
//    response still issued. Store response: rsp_rdata=32'h0.
//  - rsp_ready held low: response held indefinitely, no new accepts.
//  - Inputs sampled only at accept; changes afterward have no effect.
//  - Reset mid-operation: captured request discarded; store not yet committed (still in WAIT) is
//    dropped; response in RESP lost; outputs return to reset values next edge.
//  - rsp_valid, rsp_rdata, rsp_err are registered outputs; req_ready is decoded from state and reset.
// CONFIGURATION
//  DMEM_MISALIGN_CHECK_EN defined: request with req_addr[1:0]!=2'b00 goes through normal FSM timing
//    but performs no access; response has rsp_err=1, rsp_rdata=32'h0. Aligned requests: rsp_err=0.
//  Not defined: req_addr[1:0] ignored, rsp_err tied to 0, no checking logic instantiated.
// TESTING
//  1 Store addr 0x10 wdata 0xDEADBEEF be 4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid
//    high exactly 3 cycles after each accept (WAIT_CYCLES=2), rsp_rdata=0 on store response.
//  2 Word 0x20 = 0x11223344; store 0xAABBCCDD be 4'b0101; load 0x20 -> 0x11BB33DD.
//  3 Response pending with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata stable, req_ready=0,
//    req_valid pulses ignored; raise rsp_ready -> handshake, req_ready=1 next cycle.
//  4 DEPTH_WORDS=256: store 0x5A5A5A5A to 0x400, load 0x000 -> 0x5A5A5A5A (wrap-around).
//  5 Store to 0x30 then assert reset during WAIT; after reset load 0x30 -> prior contents unchanged;
//    rsp_valid=0, req_ready=0 during reset.
//  6 With DMEM_MISALIGN_CHECK_EN: store 0x31 -> rsp_err=1, word 0x30 unchanged; load 0x30 ->
//    rsp_err=0. Without macro: load 0x33 returns word 0x30, rsp_err=0. WAIT_CYCLES=0: rsp_valid 1 cycle after accept.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait-state latency, byte-lane stores.
// Optional misalignment check enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          wr_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          idle;
    logic          enter_resp;
    logic          acc_wr;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_mis;
    logic          unused_addr_bits;

    assign idle        = (state_q == S_IDLE);
    assign req_ready_o = idle && !reset_i;

    // With zero wait states the access uses the live request on the accept edge.
    assign enter_resp = (idle && req_valid_i && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));
    assign acc_wr     = idle ? req_write_i           : wr_q;
    assign acc_idx    = idle ? req_addr_i[AW+1:2]    : idx_q;
    assign acc_wdata  = idle ? req_wdata_i           : wdata_q;
    assign acc_be     = idle ? req_be_i              : be_q;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis_q;
    assign acc_mis = idle ? (req_addr_i[1:0] != 2'b00) : mis_q;

    always_ff @(posedge clk_i) begin
        if (idle && req_valid_i) mis_q <= (req_addr_i[1:0] != 2'b00);
    end
`else
    assign acc_mis = 1'b0;
`endif

    assign unused_addr_bits = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};

    // Array is deliberately not reset; a store still in WAIT is dropped by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enter_resp && acc_wr && !acc_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        wr_q    <= req_write_i;
                        idx_q   <= req_addr_i[AW+1:2];
                        wdata_q <= req_wdata_i;
                        be_q    <= req_be_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= (acc_wr || acc_mis) ? 32'h0 : mem_q[acc_idx];
                rsp_err_q   <= acc_mis;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
endmodule
